mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the single-issue MIPS-subset datapath. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB. It drives every datapath enable and mux select, including the 2-bit `EOp` select of the immediate extender. It also keeps a retired-instruction counter for the bench and the console.

## Interface
- No parameters; opcode/funct encodings are the MIPS standard values and are fixed in the block.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 6: IR[31:26]; valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, sampled in EXE.
- `state` out 3: current state. FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4.
- `IRWr` out 1: IR load enable.
- `PCWr` out 1: PC load enable.
- `PCSrc` out 2: 00=PC+4, 01=branch target (PC+4 + ext), 10=jump target {PC[31:28],instr_index,00}.
- `EOp` out 2: extender mode. 00=sign, 01=zero, 10=load-high (imm<<16), 11=sign then <<2.
- `ALUSrcB` out 1: 0=GPR[rt], 1=extender output.
- `ALUOp` out 2: 00=add, 01=sub, 10=or.
- `MemWr` out 1: data memory write enable.
- `RegWr` out 1: GPR write enable.
- `RegDst` out 1: 0=rt, 1=rd.
- `MemtoReg` out 1: 0=ALUOut, 1=MDR.
- `instr_cnt` out 32: retired-instruction count.

## Operation
- Supported instructions:
  - addu: op 000000, funct 100001
  - subu: op 000000, funct 100011
  - ori: 001101
  - lui: 001111
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - j: 000010
- Any other op/funct combination is unsupported and executes as a nop.
- Transitions:
  - FETCH -> DECODE, always.
  - DECODE -> FETCH for j and unsupported instructions; otherwise -> EXE.
  - EXE -> FETCH for beq; -> MEM for lw/sw; -> WB for addu/subu/ori/lui.
  - MEM -> FETCH for sw; -> WB for lw.
  - WB -> FETCH.
- Per-state outputs. Every output not listed is 0; `ALUSrcB`, `RegDst`, `MemtoReg` and `PCSrc` default to 00/0.
  - FETCH: IRWr=1, PCWr=1, PCSrc=00.
  - DECODE (j): PCWr=1, PCSrc=10.
  - EXE: ALUOp is add for lw/sw/lui, sub for subu/beq, or for ori.
    - ALUSrcB=1 for ori/lui/lw/sw.
    - beq: PCWr=zero, PCSrc=01.
  - MEM (sw): MemWr=1.
  - WB: RegWr=1. RegDst=1 for addu/subu. MemtoReg=1 for lw.
- `EOp` is purely combinational from `op`, in every state:
  - ori: 01
  - lui: 10
  - beq: 11
  - everything else: 00
- lui writes ALU(0 + ext) via the rt path; the datapath supplies 0 on port A for lui.
- `instr_cnt` increments by 1 on the final cycle of every instruction, including nops and not-taken beq. It wraps from 0xFFFF_FFFF to 0.

## Timing
- Cycles per instruction:
  - j / unsupported: 2
  - beq: 3
  - addu, subu, ori, lui, sw: 4
  - lw: 5
- All control outputs are Moore/decode combinational. They are valid within the cycle and need no output registers.
- `zero` is used only in EXE of beq.
- Reset:
  - `state` goes to FETCH and `instr_cnt` goes to 0 immediately on assertion.
  - While `reset`=1, IRWr, PCWr, MemWr and RegWr are forced to 0; the other outputs follow the FETCH decode.
  - The first FETCH write occurs at the first rising edge after deassertion.
- Reset during any state aborts the instruction: no further writes, and no count for it.
- An illegal `state` encoding (5-7) returns to FETCH on the next edge with all write enables 0.

## Test plan
- addu (op 0, funct 100001) after reset:
  - state sequence 0,1,2,4,0.
  - RegWr=1 and RegDst=1 only in state 4.
  - instr_cnt goes 0 -> 1 on the WB edge.
- lw then sw:
  - lw takes 5 cycles with MemtoReg=1 in WB.
  - sw takes 4 cycles with MemWr=1 only in MEM.
  - EOp=00 and ALUSrcB=1 in EXE of both.
  - instr_cnt=2 after both.
- beq with zero=1 in EXE:
  - PCWr=1, PCSrc=01, EOp=11.
  - With zero=0: PCWr=0.
  - Both return to FETCH after 3 cycles.
- ori then lui: EOp=01 then 10; ALUOp=10 then 00; each completes in 4 cycles.
- j, then op=111111 (unsupported):
  - j: DECODE has PCWr=1, PCSrc=10.
  - unsupported: DECODE has no writes.
  - each takes 2 cycles; instr_cnt +2 total.
- Reset and wrap:
  - Assert reset mid-MEM of sw: MemWr drops to 0 immediately, state=0, instr_cnt=0.
  - Force instr_cnt to 0xFFFF_FFFF and retire one addu: instr_cnt becomes 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle controller and the MIPS-subset datapath.
// The controller takes the slave view; the datapath (or bench) drives op/funct/zero.
interface mc_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic [2:0]  state;
  logic        IRWr;
  logic        PCWr;
  logic [1:0]  PCSrc;
  logic [1:0]  EOp;
  logic        ALUSrcB;
  logic [1:0]  ALUOp;
  logic        MemWr;
  logic        RegWr;
  logic        RegDst;
  logic        MemtoReg;
  logic [31:0] instr_cnt;

  modport slave (
    input  op, funct, zero,
    output state, IRWr, PCWr, PCSrc, EOp, ALUSrcB, ALUOp,
           MemWr, RegWr, RegDst, MemtoReg, instr_cnt
  );

  modport master (
    output op, funct, zero,
    input  state, IRWr, PCWr, PCSrc, EOp, ALUSrcB, ALUOp,
           MemWr, RegWr, RegDst, MemtoReg, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the MIPS-subset datapath,
// with Moore control outputs and a retired-instruction counter.
module mc_ctrl (
  input  logic    clk,
  input  logic    reset,
  mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;

  logic w_addu, w_subu, w_ori, w_lui, w_lw, w_sw, w_beq, w_j, w_supported;
  logic w_retire;
  logic w_irwr, w_pcwr, w_memwr, w_regwr;
  logic w_alusrcb, w_regdst, w_memtoreg;
  logic [1:0] w_pcsrc, w_aluop;

  assign w_addu = (bus.op == OP_RTYPE) && (bus.funct == FN_ADDU);
  assign w_subu = (bus.op == OP_RTYPE) && (bus.funct == FN_SUBU);
  assign w_ori  = (bus.op == OP_ORI);
  assign w_lui  = (bus.op == OP_LUI);
  assign w_lw   = (bus.op == OP_LW);
  assign w_sw   = (bus.op == OP_SW);
  assign w_beq  = (bus.op == OP_BEQ);
  assign w_j    = (bus.op == OP_J);
  assign w_supported = w_addu | w_subu | w_ori | w_lui | w_lw | w_sw | w_beq | w_j;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // w_retire marks the last cycle of a legal instruction; illegal states never count.
  always_comb begin
    w_next     = S_FETCH;
    w_retire   = 1'b0;
    w_irwr     = 1'b0;
    w_pcwr     = 1'b0;
    w_pcsrc    = 2'b00;
    w_alusrcb  = 1'b0;
    w_aluop    = 2'b00;
    w_memwr    = 1'b0;
    w_regwr    = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwr = 1'b1;
        w_pcwr = 1'b1;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_j) begin
          w_pcwr  = 1'b1;
          w_pcsrc = 2'b10;
        end
        if (w_j || !w_supported) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        if (w_subu || w_beq) w_aluop = 2'b01;
        else if (w_ori)      w_aluop = 2'b10;
        w_alusrcb = w_ori | w_lui | w_lw | w_sw;
        if (w_beq) begin
          w_pcwr   = bus.zero;
          w_pcsrc  = 2'b01;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_sw) begin
          w_memwr  = 1'b1;
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        w_regwr    = 1'b1;
        w_regdst   = w_addu | w_subu;
        w_memtoreg = w_lw;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= 32'd0;
    else if (w_retire) r_cnt <= r_cnt + 32'd1;
  end

  // Write enables are held off for the whole reset window, not just the edge.
  assign bus.IRWr      = w_irwr  & ~reset;
  assign bus.PCWr      = w_pcwr  & ~reset;
  assign bus.MemWr     = w_memwr & ~reset;
  assign bus.RegWr     = w_regwr & ~reset;
  assign bus.PCSrc     = w_pcsrc;
  assign bus.ALUSrcB   = w_alusrcb;
  assign bus.ALUOp     = w_aluop;
  assign bus.RegDst    = w_regdst;
  assign bus.MemtoReg  = w_memtoreg;
  assign bus.state     = r_state;
  assign bus.instr_cnt = r_cnt;
  assign bus.EOp       = w_ori ? 2'b01 : w_lui ? 2'b10 : w_beq ? 2'b11 : 2'b00;
endmodule
